// File: rtl/fptoint_sched_ctrl_if.sv
// Command and response handshake bundle for the FP-to-INT scheduler.
// The master side is the requester/consumer side; the slave side is the scheduler.
interface fptoint_sched_ctrl_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [4:0]   req0_cmd;
  logic [127:0] req0_data;
  logic         req1_valid;
  logic         req1_ready;
  logic [4:0]   req1_cmd;
  logic [127:0] req1_data;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [127:0] resp_data;
  logic         resp_err;

  modport master (
    output req0_valid, req0_cmd, req0_data,
    output req1_valid, req1_cmd, req1_data,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_data,
    input  req1_valid, req1_cmd, req1_data,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/fptoint_sched_ctrl.sv
// Round-robin scheduler/sequencer for the 4-lane FP-to-INT array, with two-pass pair mode.
// Optional perf counters are enabled with FPTOINT_SCHED_PERF_EN.
module fptoint_sched_ctrl #(
  parameter int unsigned ARRAY_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  fptoint_sched_ctrl_if.slave bus,
  output logic                busy,
  output logic [1:0]          dbg_state,
  output logic [127:0]        dvr_fptoint_s_in,
  output logic [4:0]          cru_fptoint_in,
  input  logic [127:0]        dr_fptoint_d_out
`ifdef FPTOINT_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_cnt0,
  output logic [31:0]         perf_cnt1,
  output logic [31:0]         perf_stall
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Once resp_valid rises, resp_id/resp_data/resp_err hold until that transfer.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [2:0]   LAT      = 3'(ARRAY_LAT);
  localparam logic [127:0] LOW_MASK = {4{32'h0000_FFFF}};

  logic [1:0]   state;
  logic         rr_ptr;
  logic [4:0]   cmd_q;
  logic [127:0] data_q;
  logic         id_q;
  logic         pass_q;
  logic [2:0]   cnt;
  logic [127:0] res_q;
  logic         err_q;

  logic         grant_id;
  logic         idle_ok;
  logic         accept;
  logic [4:0]   grant_cmd;
  logic [127:0] grant_data;
  logic         pair_eff;

  // Requester 1 wins when it is the only one asking, or when both ask and it is its turn.
  assign grant_id   = bus.req1_valid & (~bus.req0_valid | rr_ptr);
  assign idle_ok    = (state == IDLE) & ~rst;
  assign bus.req0_ready = idle_ok & bus.req0_valid & ~grant_id;
  assign bus.req1_ready = idle_ok & bus.req1_valid &  grant_id;
  assign accept     = bus.req0_ready | bus.req1_ready;
  assign grant_cmd  = grant_id ? bus.req1_cmd  : bus.req0_cmd;
  assign grant_data = grant_id ? bus.req1_data : bus.req0_data;

  assign pair_eff = cmd_q[4] & ~cmd_q[3] & ~cmd_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      cmd_q  <= '0;
      data_q <= '0;
      id_q   <= 1'b0;
      pass_q <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q  <= grant_cmd;
            data_q <= grant_data;
            id_q   <= grant_id;
            rr_ptr <= ~grant_id;
            pass_q <= 1'b0;
            cnt    <= LAT;
            err_q  <= grant_cmd[4] & (grant_cmd[3] | grant_cmd[2]);
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (pair_eff && !pass_q) begin
            // First pair pass fills the low half of every lane, then the array runs again.
            res_q  <= (res_q & ~LOW_MASK) | (dr_fptoint_d_out & LOW_MASK);
            pass_q <= 1'b1;
            cnt    <= LAT;
          end else begin
            if (pair_eff)
              res_q <= (res_q & LOW_MASK) | (dr_fptoint_d_out & ~LOW_MASK);
            else
              res_q <= dr_fptoint_d_out;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cru_fptoint_in = 5'b0;
    if (state == ISSUE)
      cru_fptoint_in = {1'b1, cmd_q[3:2], pair_eff ? {2{pass_q}} : cmd_q[1:0]};
  end

  assign dvr_fptoint_s_in = data_q;
  assign bus.resp_valid   = (state == RESP);
  assign bus.resp_id      = id_q;
  assign bus.resp_data    = res_q;
  assign bus.resp_err     = err_q;
  assign busy             = (state != IDLE);
  assign dbg_state        = state;

`ifdef FPTOINT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt0  <= '0;
      perf_cnt1  <= '0;
      perf_stall <= '0;
    end else if (state == RESP) begin
      if (bus.resp_ready) begin
        if (!id_q && perf_cnt0 != 32'hFFFF_FFFF) perf_cnt0 <= perf_cnt0 + 32'd1;
        if ( id_q && perf_cnt1 != 32'hFFFF_FFFF) perf_cnt1 <= perf_cnt1 + 32'd1;
      end else if (perf_stall != 32'hFFFF_FFFF) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fptoint_sched_ctrl.sv
// Directed bench for fptoint_sched_ctrl: vector table plus arbitration, backpressure and reset sequences.
// The array is modelled as a 1-cycle register: out lane = in lane ^ {11'h0, cru, 11'h0, cru}.
module tb_fptoint_sched_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fptoint_sched_ctrl_if bus();
  logic         busy;
  logic [1:0]   dbg_state;
  logic [127:0] s_in;
  logic [4:0]   cru;
  logic [127:0] d_out = '0;
`ifdef FPTOINT_SCHED_PERF_EN
  logic [31:0]  perf_cnt0, perf_cnt1, perf_stall;
`endif

  fptoint_sched_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .busy             (busy),
    .dbg_state        (dbg_state),
    .dvr_fptoint_s_in (s_in),
    .cru_fptoint_in   (cru),
    .dr_fptoint_d_out (d_out)
`ifdef FPTOINT_SCHED_PERF_EN
    ,
    .perf_cnt0        (perf_cnt0),
    .perf_cnt1        (perf_cnt1),
    .perf_stall       (perf_stall)
`endif
  );

  always @(posedge clk)
    if (cru[4]) d_out <= s_in ^ {4{11'h0, cru, 11'h0, cru}};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [128:0] exp_q[$];
  logic [128:0] sb_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual_id=%0d actual_data=%h (cycle %0d)", bus.resp_id, bus.resp_data, cyc);
      end else begin
        sb_e = exp_q.pop_front();
        check("resp_id", 128'(bus.resp_id), 128'(sb_e[128]));
        check("resp_data", bus.resp_data, sb_e[127:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic issue_cmd(input logic who, input logic [4:0] cmd, input logic [127:0] data,
                           input logic [127:0] exp_data, output int hcyc, output bit ok);
    ok = 1'b0;
    hcyc = 0;
    if (who) begin
      bus.req1_cmd = cmd; bus.req1_data = data; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_cmd = cmd; bus.req0_data = data; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (who ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        hcyc = cyc;
        exp_q.push_back({who, exp_data});
      end
      @(negedge clk);
    end
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout requester=%0d not accepted within 20 cycles", who);
    end
  endtask

  typedef struct {
    logic         who;
    logic [4:0]   cmd;
    logic [127:0] data;
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
    int           exp_issue;
    logic [4:0]   exp_cru_first;
    logic [4:0]   exp_cru_last;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int h;
    bit ok;
    bit seen;
    int n;
    logic [4:0] seq[8];
    logic [4:0] exp_c;
    issue_cmd(v.who, v.cmd, v.data, v.exp_data, h, ok);
    if (!ok) return;
    seen = 1'b0;
    n = 0;
    for (int j = 0; j < 30 && !seen; j++) begin
      if (bus.resp_valid) begin
        seen = 1'b1;
      end else begin
        if (cru[4]) begin
          if (n < 8) seq[n] = cru;
          if (n == 0) check($sformatf("v%0d_src_data", idx), s_in, v.data);
          n++;
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL v%0d_resp_timeout no resp_valid within 30 cycles", idx);
      return;
    end
    check($sformatf("v%0d_latency", idx), 128'(cyc - h), 128'(v.exp_lat));
    check($sformatf("v%0d_issue_cycles", idx), 128'(n), 128'(v.exp_issue));
    for (int j = 0; j < n && j < 8; j++) begin
      exp_c = (j < v.exp_issue / 2) ? v.exp_cru_first : v.exp_cru_last;
      check($sformatf("v%0d_cru_c%0d", idx, j), 128'(seq[j]), 128'(exp_c));
    end
    check($sformatf("v%0d_resp_err", idx), 128'(bus.resp_err), 128'(v.exp_err));
    check($sformatf("v%0d_resp_id", idx), 128'(bus.resp_id), 128'(v.who));
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  int   h;
  bit   ok;
  int   n0, n1, k;
  logic g;
  bit   resp_seen;

  initial begin
    vecs[0] = '{1'b0, 5'b01100, {4{32'h4049_0FDB}}, {4{32'h4055_0FC7}}, 1'b0, 3, 2, 5'b11100, 5'b11100};
    vecs[1] = '{1'b1, 5'b10000,
                {32'h8000_0001, 32'h0000_FFFF, 32'h9ABC_DEF0, 32'h1234_5678},
                {32'h8013_0011, 32'h0013_FFEF, 32'h9AAF_DEE0, 32'h1227_5668},
                1'b0, 5, 4, 5'b10000, 5'b10011};
    vecs[2] = '{1'b0, 5'b11001, {4{32'h0000_0000}}, {4{32'h0019_0019}}, 1'b1, 3, 2, 5'b11001, 5'b11001};
    vecs[3] = '{1'b1, 5'b00111, {4{32'hFFFF_FFFF}}, {4{32'hFFE8_FFE8}}, 1'b0, 3, 2, 5'b10111, 5'b10111};
    vecs[4] = '{1'b1, 5'b10100, {4{32'h1111_1111}}, {4{32'h1105_1105}}, 1'b1, 3, 2, 5'b10100, 5'b10100};

    // Reset held for two edges with both requesters asking.
    bus.req0_valid = 1'b1; bus.req0_cmd = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b1; bus.req1_cmd = '0; bus.req1_data = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", 128'(bus.req0_ready), 128'(0));
    check("rst_req1_ready", 128'(bus.req1_ready), 128'(0));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_data", bus.resp_data, 128'(0));
    check("rst_resp_id", 128'(bus.resp_id), 128'(0));
    check("rst_resp_err", 128'(bus.resp_err), 128'(0));
    check("rst_src", s_in, 128'(0));
    check("rst_cru", 128'(cru), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("rst2_req0_ready", 128'(bus.req0_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_req0_ready", 128'(bus.req0_ready), 128'(1));
    check("post_rst_req1_ready", 128'(bus.req1_ready), 128'(0));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Arbitration: fresh rr pointer, both requesters hold valid until 4 grants each.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_cmd = 5'b00000; bus.req0_data = {4{32'h0000_0000}};
    bus.req1_cmd = 5'b00000; bus.req1_data = {4{32'h0F0F_0F0F}};
    n0 = 0; n1 = 0; k = 0;
    for (int t = 0; t < 200 && (n0 < 4 || n1 < 4); t++) begin
      bus.req0_valid = (n0 < 4);
      bus.req1_valid = (n1 < 4);
      #1;
      if (bus.req0_ready && bus.req1_ready) check("arb_both_ready", 128'(1), 128'(0));
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        check($sformatf("arb_grant%0d", k), 128'(g), 128'(k % 2));
        exp_q.push_back({g, g ? {4{32'h0F1F_0F1F}} : {4{32'h0010_0010}}});
        if (g) n1++; else n0++;
        k++;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("arb_grants_total", 128'(k), 128'(8));
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("arb_all_responded", 128'(exp_q.size()), 128'(0));
    @(negedge clk);

    // Backpressure: response must hold and no new command may be accepted.
    bus.resp_ready = 1'b0;
    issue_cmd(1'b0, 5'b01100, {4{32'h4049_0FDB}}, {4{32'h4055_0FC7}}, h, ok);
    resp_seen = 1'b0;
    for (int t = 0; t < 20 && !resp_seen; t++) begin
      if (bus.resp_valid) resp_seen = 1'b1;
      else @(negedge clk);
    end
    check("bp_resp_seen", 128'(resp_seen), 128'(1));
    bus.req1_cmd = 5'b00000;
    bus.req1_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      #1;
      check("bp_resp_valid", 128'(bus.resp_valid), 128'(1));
      check("bp_resp_data", bus.resp_data, {4{32'h4055_0FC7}});
      check("bp_req1_ready", 128'(bus.req1_ready), 128'(0));
      @(negedge clk);
    end
    bus.req1_valid = 1'b0;
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_resp_valid_drop", 128'(bus.resp_valid), 128'(0));
    check("bp_idle", 128'(busy), 128'(0));

    // Reset during ISSUE abandons the command.
    issue_cmd(1'b1, 5'b00000, {4{32'h0000_0001}}, {4{32'h0010_0011}}, h, ok);
    check("mid_rst_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_state", 128'(dbg_state), 128'(0));
    check("mid_rst_cru", 128'(cru), 128'(0));
    check("mid_rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    resp_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (bus.resp_valid) resp_seen = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_resp", 128'(resp_seen), 128'(0));
    run_vec(vecs[0], 5);

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fptoint_sched_ctrl.md
Name: fptoint_sched_ctrl

Overview:
Scheduler and sequencer in front of the 4-lane FP-to-INT conversion array. Round-robin arbitration between two command requesters (valid/ready). Drives the array's 128-bit source and 5-bit micro-instruction, waits a fixed array latency, captures the 128-bit result, and returns it on a valid/ready response port tagged with the requester ID. Supports a "pair" mode that converts both 16-bit halves of every lane with two back-to-back array passes and merges the results.

Parameters:
ARRAY_LAT, 1, clock cycles from array inputs to its registered output (legal range 1..7).

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle when valid && ready
req0_cmd  input  5  [4]=pair, [3]=src_prec, [2]=dst_prec, [1]=src_pos, [0]=dst_pos
req0_data  input  128  four packed FP source lanes
req1_valid  input  1  requester 1 command valid
req1_ready  output  1  as req0_ready
req1_cmd  input  5  as req0_cmd
req1_data  input  128  as req0_data
resp_valid  output  1  result available
resp_ready  input  1  downstream accepts result
resp_id  output  1  requester that issued the command (0/1)
resp_data  output  128  converted INT result
resp_err  output  1  pair bit was set with src_prec or dst_prec = 1 (pair ignored)
busy  output  1  state != IDLE
dvr_fptoint_s_in  output  128  array source data
cru_fptoint_in  output  5  array micro-instruction {inst_vld, src_prec, dst_prec, src_pos, dst_pos}
dr_fptoint_d_out  input  128  array result

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, all outputs 0 (ready, resp_valid, resp_id, resp_data, resp_err, dvr_fptoint_s_in, cru_fptoint_in). Reset mid-operation abandons the command; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: the grant is combinational. If exactly one reqN_valid is high, grant it. If both are high, grant rr_ptr. Only the granted reqN_ready=1; the other ready=0. On handshake: latch cmd/data/id, set rr_ptr=~id, set pass=0, and go to ISSUE.
- Pair is effective only when cmd[4]=1 && cmd[3]=0 && cmd[2]=0. When cmd[4]=1 and either prec bit is 1: single pass using cmd pos bits, and resp_err=1.
- ISSUE lasts exactly ARRAY_LAT+1 cycles (down-counter). During ISSUE, cru_fptoint_in[4]=1, bits[3:2]=latched prec, and bits[1:0] depend on mode:
  - single pass: latched pos bits.
  - pair pass 0: 2'b00.
  - pair pass 1: 2'b11.
  dvr_fptoint_s_in = latched data, held stable. In every state other than ISSUE, cru_fptoint_in=0; dvr_fptoint_s_in holds its last value.
- Capture on the last ISSUE cycle, registered at the clock edge:
  - single: res = dr_fptoint_d_out.
  - pair pass 0: res[16k+15:16k] (k even, low half of each lane) <= dr_fptoint_d_out same bits; then pass=1, re-enter ISSUE with counter reloaded.
  - pair pass 1: res high half of each lane (bits 31:16 of every 32-bit lane) <= dr_fptoint_d_out same bits.
- After the final capture, go to RESP: resp_valid=1, with resp_data/resp_id/resp_err stable until resp_valid && resp_ready. Then go to IDLE, and resp_valid=0 the next cycle.
- No new command is accepted until the controller returns to IDLE. A request arriving in the same cycle as the response handshake waits one cycle.
- Latency, accept edge to resp_valid high:
  - single: ARRAY_LAT+2 cycles (3 at default).
  - pair: 2*ARRAY_LAT+3 cycles (5 at default).
- Back-to-back issue is not pipelined; throughput is one command per (latency + 1) cycles minimum.
- A requester that drops valid before the handshake loses nothing. Grant is re-evaluated every IDLE cycle.

Optional Feature:
FPTOINT_SCHED_PERF_EN: adds outputs perf_cnt0 / perf_cnt1 (32-bit each). Each counts completed responses for that requester, saturating at 32'hFFFF_FFFF, reset to 0 by rst. It also adds perf_stall (32-bit, saturating), which counts cycles in RESP with resp_ready=0. Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles with both req valid -> all outputs 0, no ready asserted. Release -> req0_ready=1 first cycle.
- Single pass: req0 cmd=5'b01100, data=4x 32'h4049_0FDB, resp_ready=1 -> cru_fptoint_in=5'b11100 for 2 cycles; resp_valid exactly 3 cycles after accept; resp_data equals the array output captured; resp_id=0.
- Arbitration: both valid continuously, 4 commands each -> grants alternate 0,1,0,1…; resp_id sequence alternates; no starvation.
- Pair mode: req1 cmd=5'b10000 -> cru bits[1:0]=00 for 2 cycles, then 11 for 2 cycles. resp_data low halves come from pass 0 and high halves from pass 1. resp_valid 5 cycles after accept; resp_err=0.
- Illegal pair: cmd=5'b11001 -> single pass with cru=5'b11001, resp_err=1.
- Backpressure and mid-op reset: resp_ready=0 for 10 cycles -> resp_valid/resp_data stable, no new ready. Assert rst during ISSUE -> IDLE next cycle, no response emitted.
